// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared defines for the instruction fetch stage
package inst_fetch_pkg;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam int          StallBus    = 6;
    localparam logic        RstEnable   = 1'b1;

    // FSM encodings for the byte-serial fetch engine
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DONE  = 2'd1,
        DRAIN = 2'd2
    } if_state_t;

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - byte-serial instruction fetch with branch drain
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int STALL_W = StallBus
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall_sign,
    input  logic                   branch_en,
    input  logic [InstAddrBus-1:0] branch_target,
    output logic                   mem_req,
    output logic [InstAddrBus-1:0] mem_addr,
    input  logic                   mem_valid,
    input  logic [7:0]             mem_rdata,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    output logic                   stallreq_if
);

    if_state_t              state, state_d;
    logic [InstAddrBus-1:0] pc, pc_d;
    logic [1:0]             cnt, cnt_d;
    logic [InstBus-1:0]     inst_buf, inst_buf_d;
    // address of the request still owed by memory after a redirect
    logic [InstAddrBus-1:0] drain_addr, drain_addr_d;

    // only the IF/ID hold bit matters here; the rest of the bus is ignored
    logic unused_stall;
    assign unused_stall = ^stall_sign;

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state      <= FETCH;
            pc         <= ZeroWord;
            cnt        <= 2'd0;
            inst_buf   <= ZeroWord;
            drain_addr <= ZeroWord;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            cnt        <= cnt_d;
            inst_buf   <= inst_buf_d;
            drain_addr <= drain_addr_d;
        end
    end

    // next-state and outputs; branch_en outranks stall and consumption
    always_comb begin
        state_d      = state;
        pc_d         = pc;
        cnt_d        = cnt;
        inst_buf_d   = inst_buf;
        drain_addr_d = drain_addr;
        mem_req      = 1'b0;
        mem_addr     = ZeroWord;
        if_pc        = ZeroWord;
        if_inst      = ZeroWord;
        stallreq_if  = 1'b0;

        if (rst != RstEnable) begin
            if_pc = pc;
            case (state)
                FETCH: begin
                    mem_req     = 1'b1;
                    mem_addr    = pc + {30'd0, cnt};
                    stallreq_if = 1'b1;
                    if (branch_en) begin
                        pc_d  = branch_target;
                        cnt_d = 2'd0;
                        // an outstanding byte must be absorbed before refetching
                        if (!mem_valid) begin
                            state_d      = DRAIN;
                            drain_addr_d = pc + {30'd0, cnt};
                        end
                    end else if (mem_valid) begin
                        inst_buf_d[{cnt, 3'b000} +: 8] = mem_rdata;
                        cnt_d = cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    mem_addr    = pc;
                    if_inst     = branch_en ? ZeroWord : inst_buf;
                    stallreq_if = branch_en;
                    if (branch_en) begin
                        pc_d    = branch_target;
                        cnt_d   = 2'd0;
                        state_d = FETCH;
                    end else if (!stall_sign[1]) begin
                        pc_d    = pc + 32'd4;
                        cnt_d   = 2'd0;
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    mem_req     = 1'b1;
                    mem_addr    = drain_addr;
                    stallreq_if = 1'b1;
                    if (branch_en) begin
                        pc_d = branch_target;
                    end
                    if (mem_valid) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed vector bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_sign;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [7:0]  mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst;
        logic        mv;
        logic [7:0]  rd;
        logic [5:0]  stall;
        logic        br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        sreq;
    } vec_t;

    vec_t vecs[$];

    inst_fetch #(.STALL_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_sign    (stall_sign),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_valid     (mem_valid),
        .mem_rdata     (mem_rdata),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .stallreq_if   (stallreq_if)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic mv, input logic [7:0] rd,
                                input logic [5:0] st, input logic br, input logic [31:0] tgt,
                                input logic req, input logic [31:0] addr, input logic [31:0] pc,
                                input logic [31:0] inst, input logic sreq);
        vec_t v;
        v.rst = r;     v.mv = mv;     v.rd = rd;   v.stall = st; v.br = br; v.tgt = tgt;
        v.req = req;   v.addr = addr; v.pc = pc;   v.inst = inst; v.sreq = sreq;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, want %h", nm, idx, got, want);
        end
    endtask

    int cyc_no = 0;

    // drive one cycle of inputs, check outputs mid-cycle, then advance one edge
    task automatic apply(input vec_t v);
        rst           = v.rst;
        mem_valid     = v.mv;
        mem_rdata     = v.rd;
        stall_sign    = v.stall;
        branch_en     = v.br;
        branch_target = v.tgt;
        @(negedge clk);
        chk("mem_req",     cyc_no, {31'd0, mem_req},     {31'd0, v.req});
        chk("mem_addr",    cyc_no, mem_addr,             v.addr);
        chk("if_pc",       cyc_no, if_pc,                v.pc);
        chk("if_inst",     cyc_no, if_inst,              v.inst);
        chk("stallreq_if", cyc_no, {31'd0, stallreq_if}, {31'd0, v.sreq});
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; mem_rdata = 8'h00; stall_sign = 6'd0;
        branch_en = 1'b0; branch_target = 32'd0;
        @(posedge clk);
        #1;

        // reset, then the first instruction 0x00100513 assembled from bytes at 0..3
        vecs.push_back(mk(1, 0, 8'h00, 6'd0, 0, 32'h0,   0, 32'h0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 6'd0, 0, 32'h0,   0, 32'h0, 32'h0, 32'h0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 6'd0, 0, 32'h0,   1, 32'h0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 8'h13, 6'd0, 0, 32'h0,   1, 32'h0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 6'd0, 0, 32'h0,   1, 32'h1, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 8'h05, 6'd0, 0, 32'h0,   1, 32'h1, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 6'd0, 0, 32'h0,   1, 32'h2, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 8'h10, 6'd0, 0, 32'h0,   1, 32'h2, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 6'd0, 0, 32'h0,   1, 32'h3, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 1, 8'h00, 6'd0, 0, 32'h0,   1, 32'h3, 32'h0, 32'h0, 1));
        foreach (vecs[i]) apply(vecs[i]);

        // DONE held by stall for 5 cycles; a stray mem_valid in DONE is ignored
        for (int i = 0; i < 5; i++) begin
            apply(mk(0, (i == 2), 8'hFF, 6'b000110, 0, 32'h0, 0, 32'h0, 32'h0, 32'h00100513, 0));
        end
        apply(mk(0, 0, 8'h00, 6'd0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h00100513, 0));

        // fetch at pc=4 proceeds back-to-back even with stall asserted
        apply(mk(0, 1, 8'h93, 6'b000110, 0, 32'h0, 1, 32'h4, 32'h4, 32'h0, 1));
        apply(mk(0, 1, 8'h00, 6'b000110, 0, 32'h0, 1, 32'h5, 32'h4, 32'h0, 1));
        apply(mk(0, 1, 8'h20, 6'b000110, 0, 32'h0, 1, 32'h6, 32'h4, 32'h0, 1));
        apply(mk(0, 1, 8'h00, 6'b000110, 0, 32'h0, 1, 32'h7, 32'h4, 32'h0, 1));
        // branch in DONE: bubble, no consumption, refetch at target
        apply(mk(0, 0, 8'h00, 6'd0, 1, 32'h40, 0, 32'h4, 32'h4, 32'h0, 1));
        apply(mk(0, 1, 8'h11, 6'd0, 0, 32'h0, 1, 32'h40, 32'h40, 32'h0, 1));
        apply(mk(0, 1, 8'h22, 6'd0, 0, 32'h0, 1, 32'h41, 32'h40, 32'h0, 1));
        // branch with byte 2 outstanding: DRAIN holds the old address
        apply(mk(0, 0, 8'h00, 6'd0, 1, 32'h100, 1, 32'h42, 32'h40, 32'h0, 1));
        apply(mk(0, 0, 8'h00, 6'd0, 0, 32'h0,   1, 32'h42, 32'h100, 32'h0, 1));
        apply(mk(0, 1, 8'hEE, 6'd0, 0, 32'h0,   1, 32'h42, 32'h100, 32'h0, 1));
        apply(mk(0, 1, 8'h37, 6'd0, 0, 32'h0,   1, 32'h100, 32'h100, 32'h0, 1));
        apply(mk(0, 1, 8'h05, 6'd0, 0, 32'h0,   1, 32'h101, 32'h100, 32'h0, 1));
        apply(mk(0, 1, 8'hAB, 6'd0, 0, 32'h0,   1, 32'h102, 32'h100, 32'h0, 1));
        apply(mk(0, 1, 8'h00, 6'd0, 0, 32'h0,   1, 32'h103, 32'h100, 32'h0, 1));
        apply(mk(0, 0, 8'h00, 6'b000010, 0, 32'h0, 0, 32'h100, 32'h100, 32'h00AB0537, 0));
        // branch beats stall on the same edge; target is the last word of the space
        apply(mk(0, 0, 8'h00, 6'b000110, 1, 32'hFFFF_FFFC, 0, 32'h100, 32'h100, 32'h0, 1));
        apply(mk(0, 1, 8'h01, 6'd0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1));
        apply(mk(0, 1, 8'h02, 6'd0, 0, 32'h0, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0, 1));
        apply(mk(0, 1, 8'h03, 6'd0, 0, 32'h0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0, 1));
        apply(mk(0, 1, 8'h04, 6'd0, 0, 32'h0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1));
        apply(mk(0, 0, 8'h00, 6'd0, 0, 32'h0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h04030201, 0));
        // pc wraps to 0; reset lands with cnt=2
        apply(mk(0, 1, 8'h55, 6'd0, 0, 32'h0, 1, 32'h0, 32'h0, 32'h0, 1));
        apply(mk(0, 1, 8'h66, 6'd0, 0, 32'h0, 1, 32'h1, 32'h0, 32'h0, 1));
        apply(mk(1, 0, 8'h00, 6'd0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 0));
        // restart from 0 with cnt=0; branch coinciding with the final byte skips DONE
        apply(mk(0, 1, 8'h77, 6'd0, 0, 32'h0,  1, 32'h0, 32'h0, 32'h0, 1));
        apply(mk(0, 1, 8'h00, 6'd0, 0, 32'h0,  1, 32'h1, 32'h0, 32'h0, 1));
        apply(mk(0, 1, 8'h00, 6'd0, 0, 32'h0,  1, 32'h2, 32'h0, 32'h0, 1));
        apply(mk(0, 1, 8'h99, 6'd0, 1, 32'h80, 1, 32'h3, 32'h0, 32'h0, 1));
        apply(mk(0, 0, 8'h00, 6'd0, 0, 32'h0,  1, 32'h80, 32'h80, 32'h0, 1));
        // branches inside DRAIN retarget pc but keep the owed address
        apply(mk(0, 0, 8'h00, 6'd0, 1, 32'h90, 1, 32'h80, 32'h80, 32'h0, 1));
        apply(mk(0, 0, 8'h00, 6'd0, 1, 32'hA0, 1, 32'h80, 32'h90, 32'h0, 1));
        apply(mk(0, 1, 8'h00, 6'd0, 0, 32'h0,  1, 32'h80, 32'hA0, 32'h0, 1));
        apply(mk(0, 0, 8'h00, 6'd0, 0, 32'h0,  1, 32'hA0, 32'hA0, 32'h0, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter STALL_W, default 6, meaning the width of the ctrl stall bus; bit 1 = hold IF/ID, bit 2 = hold ID/EX.
REQ-002 SHALL have ports in this order: clk, input, 1, clock; all state changes on the rising edge.
REQ-003 rst, input, 1: reset, synchronous, active-high.
REQ-004 stall_sign, input, STALL_W: stall vector from ctrl.
REQ-005 branch_en, input, 1: one-cycle redirect pulse from execute.
REQ-006 branch_target, input, 32: redirect PC, valid while branch_en=1.
REQ-007 mem_req, output, 1: byte read request to the memory controller.
REQ-008 mem_addr, output, 32: byte address of the current request.
REQ-009 mem_valid, input, 1: one-cycle pulse; the requested byte is on mem_rdata.
REQ-010 mem_rdata, input, 8: returned byte.
REQ-011 if_pc, output, 32: PC of the presented instruction.
REQ-012 if_inst, output, 32: presented instruction; 0 = bubble.
REQ-013 stallreq_if, output, 1: fetch not complete; asks ctrl to stall IF/IF-ID.

Function
REQ-014 SHALL hold a 32-bit register pc, a 2-bit byte counter cnt, and a 32-bit assembly buffer buf.
REQ-015 SHALL implement the FSM states FETCH, DONE and DRAIN.
REQ-016 FETCH: mem_req=1, mem_addr=pc+cnt, stallreq_if=1, if_inst=0.
REQ-017 FETCH: on mem_valid, buf[8*cnt+7:8*cnt] <= mem_rdata (little-endian) and cnt increments.
REQ-018 FETCH: on mem_valid with cnt=3, the state goes to DONE and cnt wraps to 0.
REQ-019 DONE: mem_req=0, stallreq_if=0, if_inst=buf, if_pc=pc.
REQ-020 DONE: the instruction is consumed on an edge where stall_sign[1]=0 and branch_en=0.
REQ-021 On consumption: pc <= pc+4 (mod 2^32, wrap 0xFFFFFFFC -> 0), cnt <= 0, state -> FETCH.
REQ-022 DONE: while stall_sign[1]=1, the state, pc and outputs SHALL hold indefinitely.
REQ-023 if_pc SHALL equal pc in every state.
REQ-024 Minimum latency SHALL be 4 mem_valid cycles plus 1 DONE cycle per instruction; the byte requests are back-to-back.
REQ-025 mem_addr SHALL stay stable while mem_req=1 until mem_valid; a started request is never withdrawn.
REQ-026 branch_en in DONE, or in FETCH with mem_valid=1: pc <= branch_target, cnt <= 0, state -> FETCH; the current instruction/byte is discarded.
REQ-027 branch_en in FETCH with mem_valid=0 (request outstanding): pc <= branch_target, cnt <= 0, state -> DRAIN.
REQ-028 DRAIN: mem_req and mem_addr (old address) SHALL be held, stallreq_if=1, if_inst=0.
REQ-029 DRAIN: on mem_valid, the byte is discarded and the state goes to FETCH.
REQ-030 branch_en in DRAIN: pc <= branch_target; the state stays DRAIN.
REQ-031 In any cycle with branch_en=1, if_inst SHALL be 0 and stallreq_if=1, so that no wrong-path instruction reaches IF/ID.
REQ-032 branch_en SHALL take priority over stall_sign and over consumption on the same edge.
REQ-033 Simultaneous mem_valid with cnt=3 and branch_en: the branch wins; the state does not enter DONE.
REQ-034 stall_sign SHALL NOT block byte fetching in FETCH; the assembled instruction waits in DONE.
REQ-035 mem_valid outside FETCH/DRAIN SHALL be ignored.

Reset
REQ-036 While rst=1: pc=0, cnt=0, buf=0, state=FETCH, mem_req=0, mem_addr=0, if_pc=0, if_inst=0, stallreq_if=0.
REQ-037 On the first cycle after rst falls: mem_req=1, mem_addr=0.
REQ-038 rst mid-fetch or mid-DRAIN SHALL abandon the request without draining; the memory controller is reset by the same rst.

Structure
REQ-039 A shared defines package SHALL hold ZeroWord, InstAddrBus, InstBus, StallBus, RstEnable and the FSM state encodings.
REQ-040 No sub-module; the block SHALL be a single module.

Verification
REQ-041 Reset release with memory bytes 13,05,10,00 at 0..3 returning 1 cycle after each request -> DONE with if_inst=0x00100513, if_pc=0; on the next edge pc=4.
REQ-042 DONE with stall_sign=6'b000110 held for 5 cycles -> if_inst and if_pc stable, mem_req=0; after stall clears, one edge later mem_addr=pc+4.
REQ-043 branch_en with target 0x100 while byte 2 is outstanding -> DRAIN holding mem_addr=pc+2; after mem_valid, mem_addr=0x100 and the old byte is absent from buf.
REQ-044 branch_en in DONE with stall_sign=0 -> if_inst=0 that cycle, no consumption, next mem_addr=target.
REQ-045 pc=0xFFFFFFFC consumed -> next fetch at mem_addr=0x00000000.
REQ-046 rst asserted with cnt=2 -> all outputs 0 next cycle; after release, fetch restarts at 0 with cnt=0.
